booth4_seq_mult16: RTL and testbench



---
 rtl/booth4_seq_mult16_if.sv | 22 ++
 rtl/booth4_seq_mult16.sv | 123 ++++++++++++
 tb/tb_booth4_seq_mult16.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/booth4_seq_mult16_if.sv
// Operand/product handshake bundle for booth4_seq_mult16.
// master drives operands and out_ready; slave is the multiplier.
interface booth4_seq_mult16_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p;
    logic        busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/booth4_seq_mult16.sv
// Iterative signed 16x16 radix-4 Booth multiplier, one Booth digit per cycle.
// Optional macro BOOTH4_SEQ_EARLY_TERM_EN: finish once all remaining digits encode zero.
module booth4_seq_mult16 (
    input  logic                 clk,
    input  logic                 rst,
    booth4_seq_mult16_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [31:0] acc_q, acc_d;
    logic [2:0]  idx_q, idx_d;

    logic [16:0] b_ext_s;
    logic [2:0]  digit_s;
    logic [17:0] a_ext_s;
    logic [17:0] a_dbl_s;
    logic [17:0] pp_s;
    logic [31:0] pp_shift_s;
    logic        early_s;

    // Booth digit selection and 18-bit partial product (wide enough for -2 * -32768)
    always_comb begin
        b_ext_s    = {b_q, 1'b0};
        digit_s    = 3'(b_ext_s >> {idx_q, 1'b0});
        a_ext_s    = {{2{a_q[15]}}, a_q};
        a_dbl_s    = {a_ext_s[16:0], 1'b0};
        pp_s       = 18'd0;
        case (digit_s)
            3'b001, 3'b010: pp_s = a_ext_s;
            3'b011:         pp_s = a_dbl_s;
            3'b100:         pp_s = ~a_dbl_s + 18'd1;
            3'b101, 3'b110: pp_s = ~a_ext_s + 18'd1;
            default:        pp_s = 18'd0;
        endcase
        pp_shift_s = {{14{pp_s[17]}}, pp_s} << {idx_q, 1'b0};
    end

`ifdef BOOTH4_SEQ_EARLY_TERM_EN
    logic signed [15:0] b_rem_s;

    // Remaining digits are all zero exactly when b[15:2i+1] is a sign run
    always_comb begin
        b_rem_s = $signed(b_q) >>> {idx_q, 1'b1};
        early_s = (idx_q != 3'd7) && ((b_rem_s == 16'sh0000) || (b_rem_s == 16'shFFFF));
    end
`else
    assign early_s = 1'b0;
`endif

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_CALC;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    acc_d   = 32'd0;
                    idx_d   = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                acc_d = acc_q + pp_shift_s;
                idx_d = idx_q + 3'd1;
                if ((idx_q == 3'd7) || early_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                acc_d   = 32'd0;
                idx_d   = 3'd0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            acc_q   <= 32'd0;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q == ST_CALC) || (state_q == ST_DONE);
    assign bus.p         = acc_q;

endmodule

// File: tb/tb_booth4_seq_mult16.sv
// Self-checking bench for booth4_seq_mult16: directed vectors with latency, backpressure,
// mid-operation reset and randomized stalls, scored against a plain signed multiply.
module tb_booth4_seq_mult16;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    logic [31:0] sb_q[$];

    booth4_seq_mult16_if bus ();

    booth4_seq_mult16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [15:0] av, input logic [15:0] bv);
        logic signed [31:0] x;
        logic signed [31:0] y;
        x = $signed({{16{av[15]}}, av});
        y = $signed({{16{bv[15]}}, bv});
        return 32'(x * y);
    endfunction

    function automatic int exp_lat(input logic [15:0] bv);
        logic [16:0] be;
        logic [2:0]  d;
        int k;
        be = {bv, 1'b0};
        k  = 0;
        for (int i = 0; i < 8; i++) begin
            d = be[2*i +: 3];
            if (d != 3'b000 && d != 3'b111) k = i + 1;
        end
`ifdef BOOTH4_SEQ_EARLY_TERM_EN
        return 1 + ((k < 1) ? 1 : k);
`else
        return 9;
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = 16'd0;
        bus.b         = 16'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total_cnt += 4;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else pass_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else pass_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
        if (bus.p !== 32'd0) $display("FAIL reset_p got %h want 00000000", bus.p); else pass_cnt++;
    endtask

    // One operation with out_ready high; checks accept, latency, product and return to idle.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] want, input string name);
        int n;
        logic [31:0] e;
        bus.out_ready = 1'b1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL %s_accept in_ready got %b want 1", name, bus.in_ready); else pass_cnt++;
        bus.in_valid = 1'b1;
        bus.a = av;
        bus.b = bv;
        sb_q.push_back(ref_mul(av, bv));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = 16'hDEAD;
        bus.b = 16'hBEEF;
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total_cnt += 3;
        if (n !== exp_lat(bv)) $display("FAIL %s_latency got %0d want %0d", name, n, exp_lat(bv)); else pass_cnt++;
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hXXXXXXXX;
        if (bus.p !== e) $display("FAIL %s_p got %h want %h", name, bus.p, e); else pass_cnt++;
        if (bus.p !== want) $display("FAIL %s_p_const got %h want %h", name, bus.p, want); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL %s_idle in_ready got %b want 1", name, bus.in_ready); else pass_cnt++;
    endtask

    task automatic test_directed();
        run_op(16'd3,    16'd5,    32'h0000000F, "a3b5");
        run_op(16'h8000, 16'h8000, 32'h40000000, "minmin");
        run_op(16'h7FFF, 16'h8000, 32'hC0008000, "maxmin");
        run_op(16'hFFFF, 16'hFFFF, 32'h00000001, "m1m1");
        run_op(16'h1234, 16'h0000, 32'h00000000, "bzero");
    endtask

    task automatic test_backpressure();
        int n;
        logic [31:0] e;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a = 16'h7FFF;
        bus.b = 16'h8000;
        e = ref_mul(16'h7FFF, 16'h8000);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            total_cnt += 3;
            if (bus.out_valid !== 1'b1) $display("FAIL bp_valid cyc %0d got %b want 1", c, bus.out_valid); else pass_cnt++;
            if (bus.p !== e) $display("FAIL bp_p cyc %0d got %h want %h", c, bus.p, e); else pass_cnt++;
            if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready cyc %0d got %b want 0", c, bus.in_ready); else pass_cnt++;
            bus.in_valid = 1'b1;
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        total_cnt += 2;
        if (bus.p !== e) $display("FAIL bp_release_p got %h want %h", bus.p, e); else pass_cnt++;
        @(negedge clk);
        if (bus.in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %b want 1", bus.in_ready); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL bp_no_stray_accept busy got %b want 0", bus.busy); else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a = 16'h1234;
        bus.b = 16'h5678;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (bus.busy !== 1'b1) $display("FAIL mid_busy got %b want 1", bus.busy); else pass_cnt++;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        total_cnt += 4;
        if (bus.in_ready !== 1'b1) $display("FAIL mid_rst_in_ready got %b want 1", bus.in_ready); else pass_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL mid_rst_out_valid got %b want 0", bus.out_valid); else pass_cnt++;
        if (bus.p !== 32'd0) $display("FAIL mid_rst_p got %h want 00000000", bus.p); else pass_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", bus.busy); else pass_cnt++;
        run_op(16'd7, 16'hFFF7, 32'hFFFFFFC1, "after_rst");
    endtask

    task automatic test_random(input int n_ops);
        int sent;
        int got;
        int cyc;
        logic [31:0] e;
        sent = 0;
        got  = 0;
        cyc  = 0;
        sb_q.delete();
        while (got < n_ops && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (sent < n_ops && $urandom_range(3, 0) != 0) begin
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            if ($urandom_range(15, 0) == 0) bus.a = 16'h8000;
            if ($urandom_range(15, 0) == 0) bus.b = 16'h8000;
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back(ref_mul(bus.a, bus.b));
                sent++;
            end
            bus.out_ready = ($urandom_range(3, 0) != 0);
            if (bus.out_valid && bus.out_ready) begin
                total_cnt++;
                if (sb_q.size() == 0) begin
                    $display("FAIL rand_unexpected_output p %h want none", bus.p);
                end else begin
                    e = sb_q.pop_front();
                    if (bus.p !== e) $display("FAIL rand_p op %0d got %h want %h", got, bus.p, e); else pass_cnt++;
                end
                got++;
            end
        end
        bus.in_valid = 1'b0;
        total_cnt++;
        if (got !== n_ops) $display("FAIL rand_complete got %0d want %0d", got, n_ops); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_mid_reset();
        test_random(2000);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
